// File: rtl/lcd_write_queue_pkg.sv
// rtl/lcd_write_queue_pkg.sv - shared states and LCD byte constants for lcd_write_queue
package lcd_write_queue_pkg;

  // Pacing FSM states; ST_INSERT is only reachable when auto-wrap is built in
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_INSERT
  } state_t;

  // DDRAM address / display commands
  localparam logic [7:0] LCD_CMD_LINE0 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE1 = 8'hC0;
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;

  // Bytes with special meaning when auto-wrap is built in
  localparam logic [7:0] BYTE_NEWLINE  = 8'h0A;
  localparam logic [7:0] BYTE_FORMFEED = 8'h0C;

  // Cycles WAIT_BUSY tolerates a still-ready driver before assuming it took the byte
  localparam int BUSY_TIMEOUT = 4;

endpackage

// File: rtl/lcd_write_queue_sync_fifo.sv
// rtl/lcd_write_queue_sync_fifo.sv - power-of-2 synchronous FIFO with extra-MSB pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Same index with differing wrap bit means every slot is occupied
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointers wrap naturally through the extra MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; empty pointers hide stale contents
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lcd_write_queue.sv
// rtl/lcd_write_queue.sv - buffers core LCD writes and paces them into the driver; LCD_AUTOWRAP_EN adds 2x16 line wrap
module lcd_write_queue #(
  parameter int DEPTH = 8,
  parameter int COLS  = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWrite,
  input  logic [7:0] iData,
  output logic       oFull,
  output logic       oOverflow,
  input  logic       iLcdInitialized,
  input  logic       iLcdReady,
  output logic       oLcdWrite,
  output logic [7:0] oLcdData,
  output logic       oLcdIsCmd
);

  import lcd_write_queue_pkg::*;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || COLS < 1) begin : g_bad_param
    $error("lcd_write_queue: DEPTH must be a power of 2 >= 2 and COLS >= 1");
  end

  state_t     state;
  state_t     next_state;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic [7:0] head;
  logic       load_en;
  logic [7:0] load_data;
  logic       load_cmd;
  logic [1:0] busy_cnt;
  logic       insert_due;

  assign push  = iWrite && !fifo_full;
  assign oFull = fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clock),
    .rst_n (Reset),
    .push  (push),
    .wdata (iData),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef LCD_AUTOWRAP_EN
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [CW-1:0] col;
  logic [CW-1:0] col_nx;
  logic          line;
  logic          line_nx;
  logic          pend;
  logic          pend_nx;

  assign insert_due = pend;

  // Cursor column, current line and an owed line-address command
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      col  <= '0;
      line <= 1'b0;
      pend <= 1'b0;
    end else begin
      col  <= col_nx;
      line <= line_nx;
      pend <= pend_nx;
    end
  end
`else
  assign insert_due = 1'b0;
`endif

  // Sticky record of any push dropped because the FIFO was full
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) oOverflow <= 1'b0;
    else if (iWrite && fifo_full) oOverflow <= 1'b1;
  end

  // FSM state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Counts consecutive still-ready cycles in WAIT_BUSY
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                                busy_cnt <= '0;
    else if (state == ST_WAIT_BUSY && iLcdReady) busy_cnt <= busy_cnt + 1'b1;
    else                                       busy_cnt <= '0;
  end

  // Next state, FIFO pop and byte selection (including wrap decoding)
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load_en    = 1'b0;
    load_data  = head;
    load_cmd   = 1'b0;
`ifdef LCD_AUTOWRAP_EN
    col_nx     = col;
    line_nx    = line;
    pend_nx    = pend;
`endif
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && iLcdInitialized && iLcdReady)
          next_state = insert_due ? ST_INSERT : ST_LOAD;
      end
      ST_LOAD: begin
        pop        = 1'b1;
        load_en    = 1'b1;
        next_state = ST_ISSUE;
`ifdef LCD_AUTOWRAP_EN
        if (head == BYTE_NEWLINE) begin
          load_data = line ? LCD_CMD_LINE0 : LCD_CMD_LINE1;
          load_cmd  = 1'b1;
          col_nx    = '0;
          line_nx   = !line;
        end else if (head == BYTE_FORMFEED) begin
          load_data = LCD_CMD_CLEAR;
          load_cmd  = 1'b1;
          col_nx    = '0;
          line_nx   = 1'b0;
        end else if (col == CW'(COLS - 1)) begin
          col_nx    = '0;
          line_nx   = !line;
          pend_nx   = 1'b1;
        end else begin
          col_nx    = col + 1'b1;
        end
`endif
      end
`ifdef LCD_AUTOWRAP_EN
      ST_INSERT: begin
        load_en    = 1'b1;
        load_data  = line ? LCD_CMD_LINE1 : LCD_CMD_LINE0;
        load_cmd   = 1'b1;
        pend_nx    = 1'b0;
        next_state = ST_ISSUE;
      end
`endif
      ST_ISSUE: begin
        next_state = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!iLcdReady)
          next_state = ST_WAIT_DONE;
        else if (busy_cnt == 2'(BUSY_TIMEOUT - 1))
          next_state = ST_IDLE;
      end
      ST_WAIT_DONE: begin
        if (iLcdReady) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Registered driver outputs: pulse coincides with ISSUE, byte held until next load
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oLcdWrite <= 1'b0;
      oLcdData  <= 8'h00;
      oLcdIsCmd <= 1'b0;
    end else begin
      oLcdWrite <= (next_state == ST_ISSUE);
      if (load_en) begin
        oLcdData  <= load_data;
        oLcdIsCmd <= load_cmd;
      end
    end
  end

endmodule

// File: tb/tb_lcd_write_queue.sv
// tb/tb_lcd_write_queue.sv - self-checking bench for lcd_write_queue (honours LCD_AUTOWRAP_EN)
module tb_lcd_write_queue;

  localparam int DEPTH = 8;
  localparam int COLS  = 16;

  logic       Clock;
  logic       Reset;
  logic       iWrite;
  logic [7:0] iData;
  logic       oFull;
  logic       oOverflow;
  logic       iLcdInitialized;
  logic       iLcdReady;
  logic       oLcdWrite;
  logic [7:0] oLcdData;
  logic       oLcdIsCmd;

  logic       lcd_auto;
  logic       auto_ready;
  logic       man_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pulse = -100;

  logic [7:0] obs_data[$];
  logic       obs_cmd[$];
  logic [7:0] exp_data[$];
  logic       exp_cmd[$];

  int m_col;
  bit m_line;
  bit m_pend;

  assign iLcdReady = lcd_auto ? auto_ready : man_ready;

  lcd_write_queue #(.DEPTH(DEPTH), .COLS(COLS)) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .iWrite          (iWrite),
    .iData           (iData),
    .oFull           (oFull),
    .oOverflow       (oOverflow),
    .iLcdInitialized (iLcdInitialized),
    .iLcdReady       (iLcdReady),
    .oLcdWrite       (oLcdWrite),
    .oLcdData        (oLcdData),
    .oLcdIsCmd       (oLcdIsCmd)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Records every write pulse the driver would see and checks pulse spacing
  initial begin
    forever begin
      @(negedge Clock);
      cyc++;
      if (Reset && oLcdWrite) begin
        obs_data.push_back(oLcdData);
        obs_cmd.push_back(oLcdIsCmd);
        check("pulse_gap", 32'(cyc - last_pulse >= 4), 1);
        last_pulse = cyc;
      end
    end
  end

  // Randomised LCD driver: busy for a while after most pulses, instant accept otherwise
  initial begin
    auto_ready = 1'b1;
    forever begin
      @(negedge Clock);
      if (lcd_auto && Reset && oLcdWrite && $urandom_range(0, 3) != 0) begin
        repeat ($urandom_range(0, 2)) @(negedge Clock);
        auto_ready = 1'b0;
        repeat ($urandom_range(1, 8)) @(negedge Clock);
        auto_ready = 1'b1;
      end
    end
  end

  // Screen-cursor model: what the LCD should receive for each byte the core writes
  task automatic model_push(input logic [7:0] b);
`ifdef LCD_AUTOWRAP_EN
    if (m_pend) begin
      exp_data.push_back(m_line ? 8'hC0 : 8'h80);
      exp_cmd.push_back(1'b1);
      m_pend = 0;
    end
    if (b == 8'h0A) begin
      m_line = !m_line;
      m_col  = 0;
      exp_data.push_back(m_line ? 8'hC0 : 8'h80);
      exp_cmd.push_back(1'b1);
    end else if (b == 8'h0C) begin
      m_line = 0;
      m_col  = 0;
      exp_data.push_back(8'h01);
      exp_cmd.push_back(1'b1);
    end else begin
      exp_data.push_back(b);
      exp_cmd.push_back(1'b0);
      m_col++;
      if (m_col == COLS) begin
        m_col  = 0;
        m_line = !m_line;
        m_pend = 1;
      end
    end
`else
    exp_data.push_back(b);
    exp_cmd.push_back(1'b0);
`endif
  endtask

  task automatic clear_model();
    obs_data.delete();
    obs_cmd.delete();
    exp_data.delete();
    exp_cmd.delete();
    m_col = 0;
    m_line = 0;
    m_pend = 0;
    last_pulse = -100;
  endtask

  task automatic do_reset();
    Reset  = 1'b0;
    iWrite = 1'b0;
    repeat (2) @(negedge Clock);
    clear_model();
    Reset = 1'b1;
    @(negedge Clock);
  endtask

  // Single push; returns at the negedge after the accepting edge
  task automatic push_one(input logic [7:0] b);
    iWrite = 1'b1;
    iData  = b;
    @(negedge Clock);
    iWrite = 1'b0;
  endtask

  // Push that never overruns: waits for room first
  task automatic push_paced(input logic [7:0] b);
    int n = 0;
    while (oFull && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 200) check("room_timeout", 0, 1);
    model_push(b);
    push_one(b);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (obs_data.size() < exp_data.size() && n < 4000) begin
      @(negedge Clock);
      n++;
    end
    repeat (30) @(negedge Clock);
    check({tag, "_count"}, obs_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
      check($sformatf("%s_cmd%0d", tag, i), obs_cmd[i], exp_cmd[i]);
    end
    obs_data.delete();
    obs_cmd.delete();
    exp_data.delete();
    exp_cmd.delete();
  endtask

  initial begin
    logic [7:0] b;
    int n;
    Reset = 1'b0;
    iWrite = 1'b0;
    iData = 8'h00;
    iLcdInitialized = 1'b1;
    lcd_auto = 1'b0;
    man_ready = 1'b1;
    m_col = 0;
    m_line = 0;
    m_pend = 0;
    repeat (3) @(negedge Clock);

    // reset values
    check("rst_full", oFull, 0);
    check("rst_ovf", oOverflow, 0);
    check("rst_write", oLcdWrite, 0);
    check("rst_data", oLcdData, 8'h00);
    check("rst_iscmd", oLcdIsCmd, 0);
    do_reset();

    // single push latency: pulse in the cycle after push edge + 2
    model_push(8'h41);
    push_one(8'h41);
    check("lat_n0", oLcdWrite, 0);
    @(negedge Clock);
    check("lat_n1", oLcdWrite, 0);
    @(negedge Clock);
    check("lat_n2", oLcdWrite, 1);
    check("lat_data", oLcdData, 8'h41);
    check("lat_iscmd", oLcdIsCmd, 0);
    @(negedge Clock);
    check("lat_width", oLcdWrite, 0);
    @(negedge Clock);
    man_ready = 1'b0;
    repeat (10) @(negedge Clock);
    man_ready = 1'b1;
    wait_drain("single");

    // overflow: driver busy, 9 pushes into 8 entries
    man_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'h50 + 8'(i);
      if (i < DEPTH) model_push(b);
      push_one(b);
      if (i == DEPTH - 2) check("full_at_7", oFull, 0);
      if (i == DEPTH - 1) begin
        check("full_at_8", oFull, 1);
        check("ovf_at_8", oOverflow, 0);
      end
      if (i == DEPTH) check("ovf_at_9", oOverflow, 1);
    end
    lcd_auto = 1'b1;
    wait_drain("overflow");
    check("ovf_sticky", oOverflow, 1);
    check("full_drained", oFull, 0);

    // reset asserted while ISSUE is driving the pulse
    lcd_auto = 1'b0;
    man_ready = 1'b1;
    iWrite = 1'b1;
    iData = 8'h61;
    @(negedge Clock);
    iData = 8'h62;
    @(negedge Clock);
    iWrite = 1'b0;
    n = 0;
    while (!oLcdWrite && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check("issue_seen", oLcdWrite, 1);
    Reset = 1'b0;
    #1;
    check("rst_mid_write", oLcdWrite, 0);
    check("rst_mid_ovf", oOverflow, 0);
    check("rst_mid_full", oFull, 0);
    check("rst_mid_data", oLcdData, 8'h00);
    @(negedge Clock);
    clear_model();
    Reset = 1'b1;
    repeat (20) @(negedge Clock);
    check("rst_no_output", obs_data.size(), 0);
    model_push(8'h63);
    push_one(8'h63);
    wait_drain("after_rst");

    // push and pop in the same cycle with 4 entries held
    do_reset();
    man_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      model_push(8'h70 + 8'(i));
      push_one(8'h70 + 8'(i));
    end
    man_ready = 1'b1;
    @(negedge Clock);            // edge: IDLE -> LOAD
    man_ready = 1'b0;
    model_push(8'h74);
    push_one(8'h74);             // edge: LOAD pops while this push lands
    for (int i = 5; i < 8; i++) begin
      model_push(8'h70 + 8'(i));
      push_one(8'h70 + 8'(i));
    end
    check("same_cycle_7", oFull, 0);
    model_push(8'h78);
    push_one(8'h78);
    check("same_cycle_8", oFull, 1);
    check("same_cycle_ovf", oOverflow, 0);
    lcd_auto = 1'b1;
    wait_drain("same_cycle");

    // line wrap after COLS characters
    do_reset();
    for (int i = 0; i < 16; i++) push_paced(8'h30 + 8'(i));
    push_paced(8'h40);
    wait_drain("wrap");

    // newline byte
    do_reset();
    push_paced(8'h41);
    push_paced(8'h0A);
    push_paced(8'h42);
    push_paced(8'h0C);
    push_paced(8'h43);
    wait_drain("newline");

    // nothing leaves while the LCD is not initialised
    do_reset();
    iLcdInitialized = 1'b0;
    push_paced(8'h44);
    push_paced(8'h45);
    repeat (20) @(negedge Clock);
    check("uninit_quiet", obs_data.size(), 0);
    iLcdInitialized = 1'b1;
    wait_drain("uninit");

    // randomised traffic including special bytes and random driver timing
    do_reset();
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(10, 30);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 19))
          0, 1:    b = 8'h0A;
          2:       b = 8'h0C;
          default: b = 8'($urandom_range(8'h20, 8'h7E));
        endcase
        push_paced(b);
        repeat ($urandom_range(0, 3)) @(negedge Clock);
      end
      wait_drain($sformatf("rand%0d", r));
    end
    check("rand_ovf", oOverflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_write_queue.md
# lcd_write_queue

Buffers character writes issued by the MiniAlu `LCD` instruction and paces them into the LCD driver one at a time, so the core no longer stalls its instruction pointer while the LCD is busy. It sits between the MiniAlu write strobe and data (`rWriteLCD` / `wSourceData1[7:0]`) and the LCD driver's `write_Enabled` / `iData` / `ready` handshake. When auto-wrap is compiled in, it tracks the cursor column and inserts DDRAM-address commands for 2×16 line wrap.

## Interface
- `DEPTH`, 8: FIFO entries. Must be a power of 2, ≥2.
- `COLS`, 16: characters per LCD line.
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `iWrite`  in  1  push strobe from the core; one entry per high cycle.
- `iData`  in  8  character byte accompanying `iWrite`.
- `oFull`  out  1  registered; high when the FIFO holds `DEPTH` entries.
- `oOverflow`  out  1  sticky; set when a push is dropped; cleared only by `Reset`.
- `iLcdInitialized`  in  1  LCD power-up sequence complete.
- `iLcdReady`  in  1  LCD driver idle.
- `oLcdWrite`  out  1  registered one-cycle write pulse to the driver.
- `oLcdData`  out  8  registered byte; stable from the `oLcdWrite` cycle until the next pulse.
- `oLcdIsCmd`  out  1  registered; 1 = command byte (RS=0), 0 = character (RS=1).

## Operation
- Reset values: `oFull`=0, `oOverflow`=0, `oLcdWrite`=0, `oLcdData`=8'h00, `oLcdIsCmd`=0, column=0, line=0, FIFO empty, FSM in IDLE.
- Push: accepted when `iWrite` and not `oFull`. A push while `oFull` drops the data and sets `oOverflow`.
- Push and pop in the same cycle:
  - Both happen; the count is unchanged.
  - A push is still rejected if `oFull` was high at that edge.
  - There is no empty-FIFO bypass.
- Pointers are log2(`DEPTH`)+1 bits wide with natural wrap. Full/empty is derived from the MSB comparison.
- FSM states:
  - IDLE → LOAD when the FIFO is non-empty and `iLcdInitialized`=1 and `iLcdReady`=1.
  - LOAD: pop the head entry and set `oLcdData`/`oLcdIsCmd`. Go to ISSUE.
  - ISSUE: `oLcdWrite`=1 for exactly this cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for `iLcdReady`=0, then go to WAIT_DONE. If `iLcdReady` stays 1 for 4 cycles, go to IDLE (driver accepted instantly).
  - WAIT_DONE: wait for `iLcdReady`=1, then go to IDLE.
- `iLcdInitialized` falling while not in IDLE: complete the current WAIT states. No new LOAD occurs until it is high again.

## Timing
- Push at edge N, FSM idle, LCD ready: LOAD at N+1, `oLcdWrite` high in the cycle after edge N+2.
- Minimum spacing between `oLcdWrite` pulses: 3 cycles plus the LCD busy time.
- `oFull` updates on the edge following the push/pop that changes the count.
- `Reset` low at any point: all state returns to reset values immediately, including mid-ISSUE. A pulse in progress is truncated.

## Configuration
- `LCD_AUTOWRAP_EN` defined:
  - Column counter 0..`COLS`-1 and a 1-bit line register are kept.
  - After a character is issued with column=`COLS`-1, the column resets to 0 and the line toggles. The next pending FIFO entry is preceded by an inserted command: 8'hC0 when entering line 1, 8'h80 when entering line 0.
  - Byte 8'h0A is not written. It inserts the next-line command and resets the column.
  - Byte 8'h0C is issued as command 8'h01 (clear) and resets column and line to 0.
  - Inserted commands take a full LOAD/ISSUE/WAIT sequence and do not consume FIFO entries.
- `LCD_AUTOWRAP_EN` not defined: every byte passes through as a character with `oLcdIsCmd`=0. There is no column state and no special bytes.

## Structure
- Shared package/definitions file holds:
  - FSM state encodings (IDLE, LOAD, ISSUE, WAIT_BUSY, WAIT_DONE, INSERT).
  - LCD command constants: `LCD_CMD_LINE0`=8'h80, `LCD_CMD_LINE1`=8'hC0, `LCD_CMD_CLEAR`=8'h01.
  - Special byte constants: 8'h0A, 8'h0C.
- Sub-module `sync_fifo` (parameters width, depth) holds storage, pointers and full/empty. The pacing FSM and wrap logic stay in the top module.

## Test plan
- Push 8'h41 once, `iLcdReady` drops 2 cycles after the pulse for 10 cycles → one `oLcdWrite` pulse with `oLcdData`=8'h41, `oLcdIsCmd`=0, 2 cycles after the push edge.
- `iLcdReady` held 0, push 9 bytes with `DEPTH`=8 → `oFull`=1 after the 8th push, 9th byte dropped, `oOverflow`=1. Release ready → exactly 8 bytes emitted in order.
- Push 8'h30..8'h3F, then 8'h40 with `LCD_AUTOWRAP_EN` → 16 characters, then command 8'hC0, then character 8'h40.
- Push 8'h41, 8'h0A, 8'h42 with `LCD_AUTOWRAP_EN` → 8'h41 char, 8'hC0 cmd, 8'h42 char. Without the macro → three characters including 8'h0A.
- Push and pop in the same cycle while 4 entries are held → count stays 4; output ordering is preserved.
- Assert `Reset` low during ISSUE → `oLcdWrite` drops immediately, FIFO empty, `oOverflow`=0. No output until a new push.
